// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - program-word output bus from the UART loader to the programmer
interface uart_program_loader_if;
  logic [15:0] prog_word;
  logic [14:0] prog_addr;
  logic        prog_valid;

  modport master (output prog_word, output prog_addr, output prog_valid);
  modport slave  (input prog_word, input prog_addr, input prog_valid);
endinterface

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART boot loader assembling a framed image into 16-bit program words (optional trailing checksum: UART_LOADER_CHECKSUM_EN)
module uart_program_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  uart_program_loader_if.master        prog,
  output logic                         lm_out,
  output logic                         done,
  output logic                         err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_byte_rdy, r_frame_err;
  logic        w_bit_end, w_half_end, w_rx_fall;

  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_half_end = (r_cnt == HALF_LAST);
  assign w_rx_fall  = r_rx_prev & ~r_rx_sync2;

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next state: start on a falling edge, reject glitches at mid start bit
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_half_end) w_rx_next = r_rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_end) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: synchronizer, bit timer, shifter and byte/framing pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_sync1  <= 1'b1;
      r_rx_sync2  <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_sync1  <= rx;
      r_rx_sync2  <= r_rx_sync1;
      r_rx_prev   <= r_rx_sync2;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: r_cnt <= 16'd0;
        RX_START: begin
          r_cnt     <= w_half_end ? 16'd0 : r_cnt + 16'd1;
          r_bit_idx <= 3'd0;
        end
        RX_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= 16'd0;
            r_shift   <= {r_rx_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_cnt       <= 16'd0;
            r_byte_rdy  <= r_rx_sync2;
            r_frame_err <= ~r_rx_sync2;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_cnt <= 16'd0;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO,
`ifdef UART_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE, S_ERR
  } state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t      r_state, w_next;
  logic [15:0] r_n;
  logic [15:0] r_word_cnt;
  logic [7:0]  r_hi;
  logic [15:0] r_prog_word;
  logic [14:0] r_prog_addr;
  logic        r_prog_valid;
  logic [15:0] w_n_next;
  logic        w_is_sync, w_last_word;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  assign w_n_next    = {r_n[15:8], r_shift};
  assign w_is_sync   = r_byte_rdy && (r_shift == SYNC_BYTE);
  assign w_last_word = ((r_word_cnt + 16'd1) == r_n);

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Frame next state: framing errors abort any active load
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_is_sync) w_next = S_CNT_HI;
      S_CNT_HI: begin
        if (r_frame_err)     w_next = S_ERR;
        else if (r_byte_rdy) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (r_frame_err) w_next = S_ERR;
        else if (r_byte_rdy) begin
          if (w_n_next > 16'd32768)  w_next = S_ERR;
          else if (w_n_next == 16'd0) w_next = S_AFTER_DATA;
          else                        w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (r_frame_err)     w_next = S_ERR;
        else if (r_byte_rdy) w_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (r_frame_err)     w_next = S_ERR;
        else if (r_byte_rdy) w_next = w_last_word ? S_AFTER_DATA : S_DATA_HI;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (r_frame_err)     w_next = S_ERR;
        else if (r_byte_rdy) w_next = (r_shift == r_sum) ? S_DONE : S_ERR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs; load mode is held through the final strobe cycle
  always_comb begin
    lm_out = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO: lm_out = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHK:  lm_out = 1'b1;
`endif
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
    if (r_prog_valid) lm_out = 1'b1;
  end

  // Frame datapath: count, word assembly, address counter and checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n          <= 16'd0;
      r_word_cnt   <= 16'd0;
      r_hi         <= 8'd0;
      r_prog_word  <= 16'd0;
      r_prog_addr  <= 15'd0;
      r_prog_valid <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_sum        <= 8'd0;
`endif
    end else begin
      r_prog_valid <= 1'b0;
      if (r_byte_rdy) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (w_is_sync) begin
              r_word_cnt <= 16'd0;
`ifdef UART_LOADER_CHECKSUM_EN
              r_sum      <= 8'd0;
`endif
            end
          end
          S_CNT_HI: r_n[15:8] <= r_shift;
          S_CNT_LO: r_n[7:0]  <= r_shift;
          S_DATA_HI: begin
            r_hi  <= r_shift;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum <= r_sum + r_shift;
`endif
          end
          S_DATA_LO: begin
            r_prog_word  <= {r_hi, r_shift};
            r_prog_addr  <= r_word_cnt[14:0];
            r_prog_valid <= 1'b1;
            r_word_cnt   <= r_word_cnt + 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum        <= r_sum + r_shift;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign prog.prog_word  = r_prog_word;
  assign prog.prog_addr  = r_prog_addr;
  assign prog.prog_valid = r_prog_valid;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - directed self-checking bench for uart_program_loader
module tb_uart_program_loader;
  localparam int         CPB  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic lm_out, done, err;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [15:0] s_word[$];
  logic [14:0] s_addr[$];
  logic        s_lm[$];
  int          s_time[$];

  uart_program_loader_if bus();

  uart_program_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx(rx), .prog(bus.master),
    .lm_out(lm_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.prog_valid) begin
      s_word.push_back(bus.prog_word);
      s_addr.push_back(bus.prog_addr);
      s_lm.push_back(lm_out);
      s_time.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop_val;
    bit_time();
    rx = 1'b1;
  endtask

  task automatic send_head(input logic [15:0] n);
    send_byte(SYNC, 1'b1);
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
  endtask

  // Sends nw words (w0 then w1), then the checksum (plus bump) when enabled
  task automatic send_words(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [7:0] bump);
    logic [7:0]  sum;
    logic [15:0] w;
    sum = 8'd0;
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? w0 : w1;
      send_byte(w[15:8], 1'b1);
      send_byte(w[7:0], 1'b1);
      sum = sum + w[15:8] + w[7:0];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(sum + bump, 1'b1);
`else
    sum = sum + bump;
`endif
    bit_time();
    bit_time();
  endtask

  initial begin
    int base;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.prog_valid), 32'h0);
    chk("rst_word",  32'(bus.prog_word),  32'h0);
    chk("rst_addr",  32'(bus.prog_addr),  32'h0);
    chk("rst_lm",    32'(lm_out), 32'h0);
    chk("rst_done",  32'(done),   32'h0);
    chk("rst_err",   32'(err),    32'h0);
    reset = 1'b1;
    bit_time();

    // quarter-bit low glitch in IDLE: no byte, no error
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx = 1'b1;
    bit_time(); bit_time(); bit_time();
    chk("glitch_strobes", 32'(s_word.size()), 32'd0);
    chk("glitch_err",  32'(err),  32'h0);
    chk("glitch_done", 32'(done), 32'h0);

    // good two-word image
    base = s_word.size();
    send_head(16'd2);
    chk("a_lm_during", 32'(lm_out), 32'h1);
    chk("a_done_during", 32'(done), 32'h0);
    send_words(2, 16'h1234, 16'hABCD, 8'd0);
    chk("a_count", 32'(s_word.size() - base), 32'd2);
    chk("a_w0", 32'(s_word[base]), 32'h1234);
    chk("a_a0", 32'(s_addr[base]), 32'h0);
    chk("a_w1", 32'(s_word[base+1]), 32'hABCD);
    chk("a_a1", 32'(s_addr[base+1]), 32'h1);
    chk("a_lm_strobe0", 32'(s_lm[base]), 32'h1);
    chk("a_lm_strobe1", 32'(s_lm[base+1]), 32'h1);
    chk("a_gap_ok", 32'(s_time[base+1] - s_time[base] >= 20 * CPB), 32'h1);
    chk("a_done", 32'(done), 32'h1);
    chk("a_err", 32'(err), 32'h0);
    chk("a_lm_after", 32'(lm_out), 32'h0);

`ifdef UART_LOADER_CHECKSUM_EN
    // bad checksum, then recover with the good image
    base = s_word.size();
    send_head(16'd2);
    send_words(2, 16'h1234, 16'hABCD, 8'd1);
    chk("b_count", 32'(s_word.size() - base), 32'd2);
    chk("b_err", 32'(err), 32'h1);
    chk("b_done", 32'(done), 32'h0);
    chk("b_lm", 32'(lm_out), 32'h0);
    send_head(16'd2);
    send_words(2, 16'h1234, 16'hABCD, 8'd0);
    chk("b2_err", 32'(err), 32'h0);
    chk("b2_done", 32'(done), 32'h1);
`endif

    // leading noise bytes ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    base = s_word.size();
    send_head(16'd1);
    send_words(1, 16'h0007, 16'h0000, 8'd0);
    chk("c_count", 32'(s_word.size() - base), 32'd1);
    chk("c_w0", 32'(s_word[base]), 32'h0007);
    chk("c_a0", 32'(s_addr[base]), 32'h0);
    chk("c_done", 32'(done), 32'h1);

    // framing error on the third data byte
    base = s_word.size();
    send_head(16'd2);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    bit_time(); bit_time();
    chk("d_count", 32'(s_word.size() - base), 32'd1);
    chk("d_err", 32'(err), 32'h1);
    chk("d_done", 32'(done), 32'h0);
    chk("d_lm", 32'(lm_out), 32'h0);

    // reset between hi and lo byte of the second word
    base = s_word.size();
    send_head(16'd2);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    chk("e_pre_word", 32'(bus.prog_word), 32'h1234);
    reset = 1'b0;
    #1;
    chk("e_rst_word",  32'(bus.prog_word),  32'h0);
    chk("e_rst_addr",  32'(bus.prog_addr),  32'h0);
    chk("e_rst_valid", 32'(bus.prog_valid), 32'h0);
    chk("e_rst_lm",    32'(lm_out), 32'h0);
    chk("e_rst_done",  32'(done),   32'h0);
    chk("e_rst_err",   32'(err),    32'h0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("e_no_partial", 32'(s_word.size() - base), 32'd1);
    base = s_word.size();
    send_head(16'd2);
    send_words(2, 16'hBEEF, 16'h0102, 8'd0);
    chk("e_count", 32'(s_word.size() - base), 32'd2);
    chk("e_a0", 32'(s_addr[base]), 32'h0);
    chk("e_w0", 32'(s_word[base]), 32'hBEEF);
    chk("e_a1", 32'(s_addr[base+1]), 32'h1);
    chk("e_w1", 32'(s_word[base+1]), 32'h0102);
    chk("e_done", 32'(done), 32'h1);

    // oversize count
    base = s_word.size();
    send_head(16'h8001);
    chk("f_err", 32'(err), 32'h1);
    chk("f_lm", 32'(lm_out), 32'h0);
    chk("f_count", 32'(s_word.size() - base), 32'd0);

    // empty image
    base = s_word.size();
    send_head(16'd0);
    send_words(0, 16'h0000, 16'h0000, 8'd0);
    chk("g_done", 32'(done), 32'h1);
    chk("g_err", 32'(err), 32'h0);
    chk("g_lm", 32'(lm_out), 32'h0);
    chk("g_count", 32'(s_word.size() - base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
